// File: rtl/majority_voter_n_if.sv
// Sample/vote bundle for the N-channel majority voter.
// Master drives samples and fault clear; slave returns vote and health.
interface majority_voter_n_if #(
  parameter int N     = 3,
  parameter int W     = 1,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [N*W-1:0]   in_data;
  logic             clr_fault;
  logic [W-1:0]     out;
  logic             out_valid;
  logic             tie;
  logic             no_quorum;
  logic [N-1:0]     mismatch;
  logic [N-1:0]     fault;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output in_valid,
    output in_data,
    output clr_fault,
    input  out,
    input  out_valid,
    input  tie,
    input  no_quorum,
    input  mismatch,
    input  fault,
    input  err_cnt
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  clr_fault,
    output out,
    output out_valid,
    output tie,
    output no_quorum,
    output mismatch,
    output fault,
    output err_cnt
  );
endinterface

// File: rtl/majority_voter_n.sv
// N-channel bitwise majority voter with per-channel fault latching.
// Faulted channels drop out of the vote until cleared or reset.
module majority_voter_n #(
  parameter int N            = 3,
  parameter int W            = 1,
  parameter int FAULT_THRESH = 4,
  parameter int CNT_W        = 8
) (
  input logic              clk,
  input logic              rst,
  majority_voter_n_if.slave bus
);
  localparam int AW = 6;
  localparam int TW = 4;

  logic [N-1:0]  active;
  logic [AW-1:0] acnt;
  logic [AW-1:0] ones;
  logic [AW-1:0] dbl;
  logic [W-1:0]  vote;
  logic          tie_c;
  logic          nq_c;
  logic [N-1:0]  mm_c;
  logic [TW-1:0] cnt [N];

  assign active = ~bus.fault;

  always_comb begin
    acnt  = '0;
    ones  = '0;
    dbl   = '0;
    vote  = '0;
    tie_c = 1'b0;
    mm_c  = '0;
    for (int k = 0; k < N; k++) begin
      if (active[k]) acnt = acnt + AW'(1);
    end
    // 2*ones vs A avoids any division for even active counts
    for (int i = 0; i < W; i++) begin
      ones = '0;
      for (int k = 0; k < N; k++) begin
        if (active[k] && bus.in_data[k*W+i])
          ones = ones + AW'(1);
      end
      dbl = {ones[AW-2:0], 1'b0};
      if (dbl > acnt)
        vote[i] = 1'b1;
      else if (dbl == acnt && acnt != '0)
        tie_c = 1'b1;
    end
    for (int k = 0; k < N; k++) begin
      mm_c[k] = active[k] &&
        (bus.in_data[k*W +: W] != vote);
    end
    nq_c = (acnt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
      bus.tie       <= 1'b0;
      bus.no_quorum <= 1'b0;
      bus.mismatch  <= '0;
      bus.fault     <= '0;
      bus.err_cnt   <= '0;
      for (int k = 0; k < N; k++)
        cnt[k] <= '0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.out       <= vote;
        bus.tie       <= tie_c;
        bus.no_quorum <= nq_c;
        bus.mismatch  <= mm_c;
        if (|mm_c && bus.err_cnt != '1)
          bus.err_cnt <= bus.err_cnt + CNT_W'(1);
      end
      // clear wins over counter/fault updates of the same edge
      if (bus.clr_fault) begin
        bus.fault <= '0;
        for (int k = 0; k < N; k++)
          cnt[k] <= '0;
      end else if (bus.in_valid) begin
        for (int k = 0; k < N; k++) begin
          if (!mm_c[k]) begin
            cnt[k] <= '0;
          end else if (cnt[k] + TW'(1) ==
                       TW'(FAULT_THRESH)) begin
            bus.fault[k] <= 1'b1;
            cnt[k]       <= '0;
          end else begin
            cnt[k] <= cnt[k] + TW'(1);
          end
        end
      end
    end
  end
endmodule
